// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared opcodes, FSM state and pipeline struct fields for the M-extension unit
package muldiv_pkg;

    localparam logic [2:0] MUL    = 3'b000;
    localparam logic [2:0] MULH   = 3'b001;
    localparam logic [2:0] MULHSU = 3'b010;
    localparam logic [2:0] MULHU  = 3'b011;
    localparam logic [2:0] DIV    = 3'b100;
    localparam logic [2:0] DIVU   = 3'b101;
    localparam logic [2:0] REM    = 3'b110;
    localparam logic [2:0] REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIXUP
    } muldiv_state_t;

    typedef struct packed {
        logic       is_muldiv;
        logic [2:0] funct3;
    } idex_t;

    typedef struct packed {
        logic MulDivBusyE;
    } hazard_in_t;

    // funct3[2] separates the divide family from the multiply family
    function automatic logic is_div_op(input logic [2:0] f3);
        return f3[2];
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one radix-2 shift-add multiply or restoring divide iteration
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic            i_is_div,
    input  logic [XLEN-1:0] i_acc,
    input  logic [XLEN-1:0] i_lo,
    input  logic [XLEN-1:0] i_op2,
    output logic [XLEN-1:0] o_acc,
    output logic [XLEN-1:0] o_lo
);

    logic [XLEN:0] w_sum;
    logic [XLEN:0] w_shift;
    logic [XLEN:0] w_diff;

    always_comb begin
        w_sum   = {1'b0, i_acc} + (i_lo[0] ? {1'b0, i_op2} : '0);
        w_shift = {i_acc, i_lo[XLEN-1]};
        w_diff  = w_shift - {1'b0, i_op2};
        o_acc   = '0;
        o_lo    = '0;
        if (i_is_div) begin
            // a set top bit of the difference means the trial subtract borrowed: restore
            if (!w_diff[XLEN]) begin
                o_acc = w_diff[XLEN-1:0];
                o_lo  = {i_lo[XLEN-2:0], 1'b1};
            end else begin
                o_acc = w_shift[XLEN-1:0];
                o_lo  = {i_lo[XLEN-2:0], 1'b0};
            end
        end else begin
            {o_acc, o_lo} = {w_sum, i_lo[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M/RV64M multiply-divide unit for the EX stage
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter  int XLEN  = 32,
    localparam int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    muldiv_state_t r_state, w_next_state;

    logic [2:0]       r_op;
    logic             r_neg;
    logic [XLEN-1:0]  r_acc;
    logic [XLEN-1:0]  r_lo;
    logic [XLEN-1:0]  r_op2;
    logic [CNT_W-1:0] r_cnt;
    logic [XLEN-1:0]  r_result;
    logic             r_done;

    logic             w_is_div;
    logic             w_a_signed, w_b_signed;
    logic             w_a_neg, w_b_neg;
    logic [XLEN-1:0]  w_a_mag, w_b_mag;
    logic             w_div_zero, w_ovf, w_special;
    logic [XLEN-1:0]  w_step_acc, w_step_lo;
    logic [2*XLEN-1:0] w_prod, w_prod_s;
    logic [XLEN-1:0]  w_quo, w_rem, w_fix;

    assign w_is_div   = is_div_op(funct3_i);
    assign w_a_signed = (funct3_i == MULH) || (funct3_i == MULHSU) || (funct3_i == DIV) || (funct3_i == REM);
    assign w_b_signed = (funct3_i == MULH) || (funct3_i == DIV) || (funct3_i == REM);
    assign w_a_neg    = w_a_signed & a_i[XLEN-1];
    assign w_b_neg    = w_b_signed & b_i[XLEN-1];
    assign w_a_mag    = w_a_neg ? -a_i : a_i;
    assign w_b_mag    = w_b_neg ? -b_i : b_i;
    assign w_div_zero = w_is_div && (b_i == '0);
    assign w_ovf      = ((funct3_i == DIV) || (funct3_i == REM))
                        && (a_i == {1'b1, {(XLEN-1){1'b0}}}) && (b_i == '1);
    assign w_special  = w_div_zero | w_ovf;

    muldiv_step #(.XLEN(XLEN)) u_step (
        .i_is_div (is_div_op(r_op)),
        .i_acc    (r_acc),
        .i_lo     (r_lo),
        .i_op2    (r_op2),
        .o_acc    (w_step_acc),
        .o_lo     (w_step_lo)
    );

    // Sign correction and half selection; special cases arrive with r_neg clear
    assign w_prod   = {r_acc, r_lo};
    assign w_prod_s = r_neg ? -w_prod : w_prod;
    assign w_quo    = r_neg ? -r_lo : r_lo;
    assign w_rem    = r_neg ? -r_acc : r_acc;

    always_comb begin
        w_fix = '0;
        case (r_op)
            MUL:                  w_fix = w_prod_s[XLEN-1:0];
            MULH, MULHSU, MULHU:  w_fix = w_prod_s[2*XLEN-1:XLEN];
            DIV, DIVU:            w_fix = w_quo;
            default:              w_fix = w_rem;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start_i) w_next_state = w_special ? FIXUP : CALC;
            CALC:    if (r_cnt == CNT_W'(1)) w_next_state = FIXUP;
            FIXUP:   w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
        if (flush_i) w_next_state = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op     <= '0;
            r_neg    <= 1'b0;
            r_acc    <= '0;
            r_lo     <= '0;
            r_op2    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (!flush_i) begin
                case (r_state)
                    IDLE: if (start_i) begin
                        r_op  <= funct3_i;
                        r_cnt <= CNT_W'(XLEN);
                        r_op2 <= w_is_div ? w_b_mag : w_a_mag;
                        if (w_div_zero) begin
                            r_lo  <= '1;
                            r_acc <= a_i;
                            r_neg <= 1'b0;
                        end else if (w_ovf) begin
                            r_lo  <= a_i;
                            r_acc <= '0;
                            r_neg <= 1'b0;
                        end else begin
                            r_lo  <= w_is_div ? w_a_mag : w_b_mag;
                            r_acc <= '0;
                            r_neg <= (funct3_i == REM) ? w_a_neg : (w_a_neg ^ w_b_neg);
                        end
                    end
                    CALC: begin
                        r_acc <= w_step_acc;
                        r_lo  <= w_step_lo;
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                    FIXUP: begin
                        r_result <= w_fix;
                        r_done   <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy_o   = (r_state != IDLE);
    assign done_o   = r_done;
    assign result_o = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - scoreboard bench for muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_i = 1'b0;
    logic [2:0]  funct3_i = 3'b000;
    logic [31:0] a_i = '0;
    logic [31:0] b_i = '0;
    logic        flush_i = 1'b0;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;

    typedef struct {
        logic [31:0] res;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    logic        prev_done = 1'b0;
    logic [31:0] last_exp = '0;

    muldiv_unit #(.XLEN(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .start_i  (start_i),
        .funct3_i (funct3_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .flush_i  (flush_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ref_md(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (f)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
        return 33;
    endfunction

    task automatic start_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input bit push);
        exp_t e;
        funct3_i = f;
        a_i      = a;
        b_i      = b;
        start_i  = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        if (push) begin
            e.res = ref_md(f, a, b);
            e.cyc = cyc + ref_latency(f, a, b);
            exp_q.push_back(e);
            last_exp = e.res;
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done_o && n < 60);
        if (!done_o) begin
            n_checks++;
            n_errors++;
            $display("FAIL done_timeout: no done_o within 60 cycles (cycle %0d)", cyc);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            prev_done = 1'b0;
        end else begin
            if (done_o) begin
                check("done_single_pulse", 64'(prev_done), 64'd0);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_done: result %0h with empty scoreboard (cycle %0d)", result_o, cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("result", 64'(result_o), 64'(e.res));
                    check("latency_cycle", 64'(cyc), 64'(e.cyc));
                end
            end
            prev_done = done_o;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  f;
        logic [31:0] a, b;
        int          r;

        repeat (3) @(negedge clk);
        check("reset_busy", 64'(busy_o), 64'd0);
        check("reset_done", 64'(done_o), 64'd0);
        check("reset_result", 64'(result_o), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // MUL 7 x -3 with busy profile across the run
        start_op(3'd0, 32'd7, 32'hFFFF_FFFD, 1'b1);
        @(negedge clk);
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            check("busy_during_calc", 64'(busy_o), 64'd1);
        end
        @(negedge clk);
        check("busy_in_done_cycle", 64'(busy_o), 64'd0);
        check("done_at_33", 64'(done_o), 64'd1);

        // high products, divides and special cases, issued back to back
        start_op(3'd1, 32'h8000_0000, 32'h8000_0000, 1'b1); wait_done();
        start_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1); wait_done();
        start_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1); wait_done();
        start_op(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b1);         wait_done();
        start_op(3'd6, 32'hFFFF_FFF9, 32'd2, 1'b1);         wait_done();
        start_op(3'd5, 32'd100, 32'd7, 1'b1);               wait_done();
        start_op(3'd7, 32'd100, 32'd7, 1'b1);               wait_done();
        start_op(3'd4, 32'd5, 32'd0, 1'b1);                 wait_done();
        start_op(3'd6, 32'd5, 32'd0, 1'b1);                 wait_done();
        start_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1); wait_done();
        start_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1); wait_done();

        // start held high while busy must not disturb the running op
        start_op(3'd0, 32'd1234, 32'd5678, 1'b1);
        repeat (5) @(negedge clk);
        funct3_i = 3'd4; a_i = 32'hDEAD_BEEF; b_i = 32'd3; start_i = 1'b1;
        repeat (15) @(negedge clk);
        start_i = 1'b0;
        wait_done();

        // flush mid-operation: no done_o, result_o holds
        @(negedge clk);
        start_op(3'd5, 32'd999, 32'd10, 1'b0);
        repeat (10) @(negedge clk);
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        check("flush_busy", 64'(busy_o), 64'd0);
        check("flush_result_hold", 64'(result_o), 64'(last_exp));
        repeat (40) @(negedge clk);
        check("flush_result_hold_late", 64'(result_o), 64'(last_exp));

        // flush together with start in IDLE: not started
        funct3_i = 3'd0; a_i = 32'd2; b_i = 32'd2; start_i = 1'b1; flush_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0; flush_i = 1'b0;
        check("flush_beats_start", 64'(busy_o), 64'd0);
        @(negedge clk);

        // randomized ops, each started in the previous op's done cycle
        for (int i = 0; i < 40; i++) begin
            f = 3'($urandom_range(7));
            a = $urandom;
            b = $urandom;
            r = $urandom_range(9);
            if (r == 0) b = 32'd0;
            if (r == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            if (r == 2) b = 32'($urandom_range(15));
            if (r == 3) a = 32'h8000_0000;
            start_op(f, a, b, 1'b1);
            wait_done();
        end

        // asynchronous reset in the middle of a divide
        start_op(3'd4, 32'd1000, 32'd7, 1'b0);
        repeat (15) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("async_reset_busy", 64'(busy_o), 64'd0);
        check("async_reset_done", 64'(done_o), 64'd0);
        check("async_reset_result", 64'(result_o), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        start_op(3'd0, 32'd3, 32'd4, 1'b1);
        wait_done();
        repeat (3) @(negedge clk);

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative RV32M/RV64M multiply-divide unit for the EX stage. It sits beside the single-cycle ALU and is started by the EX stage when it decodes an M-extension funct3. It computes one radix-2 shift-add (multiply) or restoring (divide) step per cycle. While it runs, busy_o drives the hazard unit's StallF/StallD/stall-E path. Results return on a one-cycle done_o pulse.

Parameters:
XLEN, 32, operand/result width (32 or 64)
CNT_W, $clog2(XLEN)+1, iteration counter width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous active-high reset
start_i  in  1  request; sampled only when idle
funct3_i  in  3  M-ext op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
a_i  in  XLEN  rs1 operand (already forwarded)
b_i  in  XLEN  rs2 operand (already forwarded)
flush_i  in  1  abort in-flight op (PCSrcE/FlushE)
busy_o  out  1  state != IDLE; hazard unit stalls on it
done_o  out  1  one-cycle pulse, result_o valid
result_o  out  XLEN  result; held until next done_o

Behaviour:
- Reset: state=IDLE, busy_o=0, done_o=0, result_o=0, counter and all working regs=0. Reset applies at any point, including mid-operation. No done_o is produced for an aborted op.
- States:
  - IDLE: start_i=1 latches op/operands at edge E0.
  - After E0, normal case -> CALC, counter=XLEN.
  - After E0, special divide case -> FIXUP.
- CALC: one iteration per edge, counter decrements. After XLEN iterations -> FIXUP.
- FIXUP: one edge that
  - applies sign correction,
  - selects low/high product or quotient/remainder,
  - registers result_o,
  - pulses done_o,
  - returns to IDLE.
- Latency from the start edge E0 to the done_o cycle: XLEN+1 edges normally (33 for XLEN=32); 1 edge for special cases.
- Sign handling:
  - Operands are converted to magnitudes; signs are recorded per op.
  - MULHSU: a_i signed, b_i unsigned.
  - Product is 2*XLEN wide. MUL returns the low half; MULH* return the high half.
  - Quotient is negated if the operand signs differ (signed ops only).
  - Remainder takes the dividend's sign.
- Special cases, resolved at E0 with no iterations:
  - divisor=0: DIV/DIVU -> all ones; REM/REMU -> a_i.
  - signed overflow (a_i = most-negative, b_i = -1): DIV -> a_i; REM -> 0.
- busy_o is combinational from the state register: high in CALC and FIXUP, low in IDLE, including the done_o cycle.
- start_i while busy_o=1 is ignored; the operands are not re-latched.
- start_i in the same cycle as done_o is accepted, because state is IDLE, giving back-to-back ops.
- flush_i=1: the next edge forces IDLE, suppresses done_o, and leaves result_o unchanged.
- flush_i and start_i together in IDLE: flush wins and the op is not started.
- done_o is never asserted for two consecutive cycles from a single op.

Decomposition:
- Shared package gets two additions:
  - muldiv opcode localparams (MUL..REMU = funct3 encodings), added to alu_pkg;
  - a muldiv_state_t enum {IDLE, CALC, FIXUP}.
- idex_t gains an is_muldiv bit. The hazard_in struct gains a MulDivBusyE bit.
- One natural sub-module: muldiv_step. It is combinational, does one shift-add/subtract-restore iteration, and is parametrised by XLEN.

Test Plan:
1. MUL a=7, b=0xFFFFFFFD (-3) -> done_o exactly 33 cycles after the start edge; result_o = 0xFFFFFFEB; busy_o high for cycles 1-32.
2. High products:
   - MULH 0x80000000 x 0x80000000 -> 0x40000000;
   - MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE;
   - MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
3. Divides:
   - DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD;
   - REM same operands -> 0xFFFFFFFF;
   - DIVU 100/7 -> 14;
   - REMU 100/7 -> 2.
4. Special cases, each with done_o exactly one cycle after start:
   - DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5;
   - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
5. Handshake:
   - start, then start_i held high with new operands at cycle 5 -> first result is unaffected;
   - flush_i at cycle 10 -> busy_o low next cycle, no done_o, result_o holds its old value;
   - start in a done_o cycle -> second op done 33 cycles later.
6. Reset asserted asynchronously at cycle 15 of a DIV -> busy_o, done_o, result_o all 0 immediately; after release, MUL 3x4 -> 12.
